// File: rtl/ltssm_poll_ctrl_pkg.sv
// Shared LTSSM state/substate encodings reported on ts_info, plus the
// local state encoding of the Polling controller FSM.
package ltssm_poll_ctrl_pkg;

    localparam logic [3:0] LTSSM_POLL        = 4'h2;
    localparam logic [3:0] LTSSM_POLL_ACTIVE = 4'h0;
    localparam logic [3:0] LTSSM_POLL_CFG    = 4'h1;
    localparam logic [3:0] LTSSM_CFG         = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_P_ACT = 2'd1,
        ST_P_CFG = 2'd2,
        ST_CFG   = 2'd3
    } poll_state_t;

endpackage

// File: rtl/ltssm_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ltssm_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg < limit)) begin
            count_next = count_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/ltssm_poll_ctrl.sv
// LTSSM Polling controller: sequences Poll.Active -> Poll.Config -> Configuration,
// handshakes substate changes with the TS analyzer and enforces TX counts and timeouts.
import ltssm_poll_ctrl_pkg::*;

module ltssm_poll_ctrl #(
    parameter int TX_NUM_ACT = 1024,
    parameter int TX_NUM_CFG = 16,
    parameter int TO_ACT     = 24000000,
    parameter int TO_CFG     = 48000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ts_update_ack,
    input  logic       tsa_p_a2c,
    input  logic       tsa_p2c,
    input  logic       tx_ts_sent,
    output logic [7:0] ts_info,
    output logic       ts_update,
    output logic       ts_stop,
    output logic       to_tsa_ts_sent_enough,
    output logic       tx_ts_en,
    output logic       tx_ts_type,
    output logic       cfg_entry,
    output logic       poll_fail
);

    localparam logic [15:0] TX_ACT_W = 16'(TX_NUM_ACT);
    localparam logic [15:0] TX_CFG_W = 16'(TX_NUM_CFG);
    localparam logic [31:0] TO_ACT_W = 32'(TO_ACT);
    localparam logic [31:0] TO_CFG_W = 32'(TO_CFG);

    poll_state_t state_reg, state_next;
    logic [7:0]  ts_info_reg, ts_info_next;
    logic        ts_update_reg, ts_update_next;
    logic        ts_stop_reg, ts_stop_next;
    logic        sent_enough_reg, sent_enough_next;
    logic        tx_ts_en_reg, tx_ts_en_next;
    logic        tx_ts_type_reg, tx_ts_type_next;
    logic        cfg_entry_reg, cfg_entry_next;
    logic        poll_fail_reg, poll_fail_next;

    logic [15:0] tx_cnt;
    logic [15:0] tx_target;
    logic [31:0] timer_cnt;
    logic        in_poll;
    logic        cnt_clr;
    logic        hs_done;
    logic        enough_hit;

    assign in_poll   = (state_reg == ST_P_ACT) || (state_reg == ST_P_CFG);
    assign tx_target = (state_reg == ST_P_CFG) ? TX_CFG_W : TX_ACT_W;
    assign hs_done   = ~ts_update_reg;
    // Both counters restart on every substate change and stay idle outside Polling.
    assign cnt_clr   = ~in_poll || (state_next != state_reg);
    // Count as it will read after this edge, so the flag lands one cycle after the pulse.
    assign enough_hit = (tx_cnt >= tx_target) ||
                        (tx_ts_sent && ((tx_cnt + 16'd1) >= tx_target));

    ltssm_sat_cnt #(.W(16)) u_tx_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (tx_ts_sent),
        .limit (tx_target),
        .count (tx_cnt)
    );

    ltssm_sat_cnt #(.W(32)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (1'b1),
        .limit (32'hFFFF_FFFF),
        .count (timer_cnt)
    );

    always_comb begin
        state_next     = state_reg;
        ts_info_next   = ts_info_reg;
        ts_update_next = ts_update_reg & ~ts_update_ack;
        ts_stop_next   = 1'b0;
        poll_fail_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_P_ACT;
                    ts_info_next   = {LTSSM_POLL, LTSSM_POLL_ACTIVE};
                    ts_update_next = 1'b1;
                end
            end
            ST_P_ACT: begin
                // Success is tested first so it wins over a coincident timeout.
                if (hs_done && sent_enough_reg && tsa_p_a2c) begin
                    state_next     = ST_P_CFG;
                    ts_info_next   = {LTSSM_POLL, LTSSM_POLL_CFG};
                    ts_update_next = 1'b1;
                end else if (timer_cnt == TO_ACT_W) begin
                    state_next     = ST_IDLE;
                    ts_info_next   = 8'h00;
                    ts_update_next = 1'b0;
                    ts_stop_next   = 1'b1;
                    poll_fail_next = 1'b1;
                end
            end
            ST_P_CFG: begin
                if (hs_done && sent_enough_reg && tsa_p2c) begin
                    state_next     = ST_CFG;
                    ts_info_next   = {LTSSM_CFG, 4'h0};
                    ts_update_next = 1'b0;
                    ts_stop_next   = 1'b1;
                end else if (timer_cnt == TO_CFG_W) begin
                    state_next     = ST_IDLE;
                    ts_info_next   = 8'h00;
                    ts_update_next = 1'b0;
                    ts_stop_next   = 1'b1;
                    poll_fail_next = 1'b1;
                end
            end
            ST_CFG: begin
                state_next = ST_CFG;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        tx_ts_en_next    = (state_next == ST_P_ACT) || (state_next == ST_P_CFG);
        tx_ts_type_next  = (state_next == ST_P_CFG);
        cfg_entry_next   = (state_next == ST_CFG);
        sent_enough_next = ~cnt_clr && enough_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            ts_info_reg     <= 8'h00;
            ts_update_reg   <= 1'b0;
            ts_stop_reg     <= 1'b0;
            sent_enough_reg <= 1'b0;
            tx_ts_en_reg    <= 1'b0;
            tx_ts_type_reg  <= 1'b0;
            cfg_entry_reg   <= 1'b0;
            poll_fail_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ts_info_reg     <= ts_info_next;
            ts_update_reg   <= ts_update_next;
            ts_stop_reg     <= ts_stop_next;
            sent_enough_reg <= sent_enough_next;
            tx_ts_en_reg    <= tx_ts_en_next;
            tx_ts_type_reg  <= tx_ts_type_next;
            cfg_entry_reg   <= cfg_entry_next;
            poll_fail_reg   <= poll_fail_next;
        end
    end

    assign ts_info               = ts_info_reg;
    assign ts_update             = ts_update_reg;
    assign ts_stop               = ts_stop_reg;
    assign to_tsa_ts_sent_enough = sent_enough_reg;
    assign tx_ts_en              = tx_ts_en_reg;
    assign tx_ts_type            = tx_ts_type_reg;
    assign cfg_entry             = cfg_entry_reg;
    assign poll_fail             = poll_fail_reg;

endmodule

// File: doc/ltssm_poll_ctrl.md
LTSSM_POLL_CTRL -- requirements
Module: ltssm_poll_ctrl

Interface
REQ-001 SHALL have parameter TX_NUM_ACT, default 1024, TS1s to transmit in Poll.Active before exit is allowed.
REQ-002 SHALL have parameter TX_NUM_CFG, default 16, TS2s to transmit in Poll.Config before exit is allowed.
REQ-003 SHALL have parameter TO_ACT, default 24000000, Poll.Active timeout in clk cycles.
REQ-004 SHALL have parameter TO_CFG, default 48000000, Poll.Config timeout in clk cycles.
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports: clk in 1, 1GHz sys clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: start in 1, Detect complete (level); ts_update_ack in 1, analyzer ack pulse; tsa_p_a2c in 1, analyzer Poll.Active exit-ready; tsa_p2c in 1, analyzer Poll.Config exit-ready; tx_ts_sent in 1, one-cycle pulse per TS transmitted.
REQ-007 SHALL have ports: ts_info out 8, {state[7:4], sub_state[3:0]}; ts_update out 1, analyzer update request; ts_stop out 1, analyzer stop pulse; to_tsa_ts_sent_enough out 1, TX target met; tx_ts_en out 1, TS transmitter enable; tx_ts_type out 1, 0=TS1 1=TS2; cfg_entry out 1, level, Configuration reached; poll_fail out 1, timeout pulse.

Function
REQ-008 SHALL implement FSM IDLE, P_ACT, P_CFG, CFG; all outputs registered.
REQ-009 SHALL, in IDLE with start=1, move to P_ACT next cycle; start ignored in all other states.
REQ-010 SHALL, on entry to P_ACT/P_CFG, load ts_info={`POLL,`POLL_ACTIVE}/{`POLL,`POLL_CFG}, assert ts_update, clear tx counter and timer in the same edge.
REQ-011 SHALL hold ts_update high until ts_update_ack sampled 1, deasserting ts_update on that same edge; "handshake done" = ts_update low since entry.
REQ-012 SHALL count tx_ts_sent pulses in 16-bit counter saturating at current target (TX_NUM_ACT in P_ACT, TX_NUM_CFG in P_CFG); pulse in the transition cycle is discarded.
REQ-013 SHALL drive to_tsa_ts_sent_enough=1 when counter>=target, one cycle after the qualifying pulse; cleared on substate change.
REQ-014 SHALL assert tx_ts_en in P_ACT and P_CFG; tx_ts_type=0 in P_ACT, 1 in P_CFG.
REQ-015 SHALL move P_ACT->P_CFG when handshake done, sent_enough=1, tsa_p_a2c=1; ignore tsa_p2c in P_ACT.
REQ-016 SHALL move P_CFG->CFG when handshake done, sent_enough=1, tsa_p2c=1; ignore tsa_p_a2c (stale) in P_CFG.
REQ-017 SHALL count a 32-bit timer from substate entry, saturating; timer==TO_ACT in P_ACT or TO_CFG in P_CFG -> IDLE with poll_fail one-cycle pulse.
REQ-018 SHALL give success priority over timeout in the same cycle.
REQ-019 SHALL pulse ts_stop one cycle on entry to CFG or to IDLE from timeout.
REQ-020 SHALL hold CFG with cfg_entry=1, tx_ts_en=0, ts_info={`CFG,4'h0} until rst.
REQ-021 SHALL ignore ts_update_ack when ts_update is low.

Reset
REQ-022 SHALL, on rst, enter IDLE; ts_info=8'h00, ts_update=0, ts_stop=0, to_tsa_ts_sent_enough=0, tx_ts_en=0, tx_ts_type=0, cfg_entry=0, poll_fail=0, counters 0.
REQ-023 SHALL let rst mid-handshake abandon ts_update immediately with no ts_stop pulse.

Structure
REQ-024 SHALL take `POLL, `POLL_ACTIVE, `POLL_CFG, `CFG encodings from shared define.v; FSM state encodings local.
REQ-025 SHALL implement as a single module; one sub-module ltssm_sat_cnt (parameterised saturating counter) for tx counter and timer is acceptable.

Verification (TX_NUM_ACT=8, TX_NUM_CFG=4, TO_ACT=200, TO_CFG=100)
REQ-026 SHALL cover: start=1, ack 3 cycles later, 8 tx pulses, tsa_p_a2c=1 -> ts_info=8'h?? {POLL,POLL_CFG}, tx_ts_type=1, ts_update re-asserted.
REQ-027 SHALL cover: full pass with 4 TS2s, tsa_p2c=1 -> cfg_entry=1, ts_stop one pulse, tx_ts_en=0.
REQ-028 SHALL cover: P_ACT, no tsa_p_a2c -> poll_fail pulse exactly 200 cycles after entry, state IDLE.
REQ-029 SHALL cover: tsa_p_a2c=1 held stale from P_ACT into P_CFG, tsa_p2c=0 -> stay P_CFG, timeout at 100 cycles.
REQ-030 SHALL cover: tsa_p_a2c=1 and timer==200 same cycle -> P_CFG, no poll_fail.
REQ-031 SHALL cover: rst while ts_update=1 -> next cycle ts_update=0, all outputs at reset values.
